sync_down_counter: RTL and testbench

- Synchronous down counter: the count-down counterpart to the team's T-flip-flop up counter.
- Loadable start value; counts toward zero on each enabled cycle.
- Flags terminal count, then either stops (one-shot) or reloads (periodic).
- Used as a programmable delay/timeout and periodic tick source next to the up counters in the Behaviour library.

---
 rtl/sync_down_counter_pkg.sv | 12 +
 rtl/sync_down_counter_down_tff_stage.sv | 30 +++
 rtl/sync_down_counter.sv | 123 ++++++++++++
 tb/tb_sync_down_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the synchronous down counter: state encoding and default width.
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/sync_down_counter_down_tff_stage.sv
// One counter bit: a T flip-flop with synchronous active-low reset and parallel load.
module down_tff_stage (
    input  logic clock,
    input  logic reset,
    input  logic load_en,
    input  logic load_bit,
    input  logic toggle,
    output logic bit_q
);

    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (load_en) begin
            bit_d = load_bit;
        end else if (toggle) begin
            bit_d = ~bit_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot / periodic terminal count, built from T flip-flop stages.
// Optional registered Gray-coded count output when SYNC_DOWN_COUNTER_GRAY_OUT_EN is defined.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] load_bits;
    logic [WIDTH-1:0] toggle;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic             dec_en, term_en, stage_load;

    always_comb begin
        dec_en     = 1'b0;
        term_en    = 1'b0;
        state_d    = state_q;
        reload_d   = reload_q;
        load_bits  = '0;
        if (!load && state_q == COUNT && enable) begin
            // The 1->0 / 1->reload step is a parallel load, so the counter never borrows past 0.
            if (count_q == WIDTH'(1)) begin
                term_en = 1'b1;
            end else if (count_q != '0) begin
                dec_en = 1'b1;
            end
        end
        stage_load = load | term_en;
        if (load) begin
            load_bits = load_value;
            reload_d  = load_value;
            state_d   = (load_value != '0) ? COUNT : IDLE;
        end else if (term_en) begin
            load_bits = auto_reload ? reload_q : '0;
            state_d   = auto_reload ? COUNT : DONE;
        end
        tc_d = term_en;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_lsb
                assign toggle[gi] = dec_en;
            end else begin : g_upper
                assign toggle[gi] = dec_en && (count_q[gi-1:0] == '0);
            end

            down_tff_stage u_stage (
                .clock    (clock),
                .reset    (reset),
                .load_en  (stage_load),
                .load_bit (load_bits[gi]),
                .toggle   (toggle[gi]),
                .bit_q    (count_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == COUNT);
            done_q   <= (state_d == DONE);
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_gray_q, count_gray_d;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_next
            assign count_d[gi] = stage_load ? load_bits[gi]
                               : (toggle[gi] ? ~count_q[gi] : count_q[gi]);
        end
    endgenerate

    assign count_gray_d = count_d ^ (count_d >> 1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_gray_q <= '0;
        end else begin
            count_gray_q <= count_gray_d;
        end
    end

    assign count_gray = count_gray_q;
`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter (WIDTH=3): per-cycle model compare plus literal expectations.
module tb_sync_down_counter;

    localparam int W = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         tc, done, busy;
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
    logic [W-1:0] count_gray;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: 0 idle, 1 counting, 2 done.
    int m_count = 0, m_reload = 0, m_state = 0, m_tc = 0;

    sync_down_counter #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .done        (done),
        .busy        (busy)
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
        ,
        .count_gray  (count_gray)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        m_tc = 0;
        if (!reset) begin
            m_count = 0; m_reload = 0; m_state = 0;
        end else if (load) begin
            m_count  = int'(load_value);
            m_reload = int'(load_value);
            m_state  = (load_value != 0) ? 1 : 0;
        end else if (m_state == 1 && enable) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (auto_reload) m_count = m_reload;
                else begin
                    m_count = 0;
                    m_state = 2;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("model_count", int'(count), m_count);
            chk("model_tc", int'(tc), m_tc);
            chk("model_busy", int'(busy), int'(m_state == 1));
            chk("model_done", int'(done), int'(m_state == 2));
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
            chk("model_gray", int'(count_gray), m_count ^ (m_count >> 1));
`endif
        end
    end

    // One clock: drive inputs, take the edge, then check hand-computed expectations.
    task automatic go(input bit l, input int lv, input bit en, input bit ar, input bit rst,
                      input int e_count, input int e_tc, input int e_busy, input int e_done);
        @(negedge clock);
        #1;
        load = l; load_value = W'(lv); enable = en; auto_reload = ar; reset = rst;
        @(posedge clock);
        #2;
        check_en = 1'b1;
        chk("lit_count", int'(count), e_count);
        chk("lit_tc", int'(tc), e_tc);
        chk("lit_busy", int'(busy), e_busy);
        chk("lit_done", int'(done), e_done);
        $display("txn load=%0b lv=%0d en=%0b ar=%0b rst=%0b -> count=%0d tc=%0b busy=%0b done=%0b",
                 l, lv, en, ar, rst, count, tc, busy, done);
    endtask

    initial begin
        // Reset wins over load.
        go(1, 5, 0, 0, 0, 0, 0, 0, 0);
        go(1, 5, 0, 0, 0, 0, 0, 0, 0);
        // One-shot from 3.
        go(1, 3, 0, 0, 1, 3, 0, 1, 0);
        go(0, 0, 1, 0, 1, 2, 0, 1, 0);
        go(0, 0, 1, 0, 1, 1, 0, 1, 0);
        go(0, 0, 1, 0, 1, 0, 1, 0, 1);
        go(0, 0, 1, 0, 1, 0, 0, 0, 1);
        go(0, 0, 1, 1, 1, 0, 0, 0, 1);
        // Periodic from 4.
        go(1, 4, 0, 1, 1, 4, 0, 1, 0);
        for (int r = 0; r < 2; r++) begin
            go(0, 0, 1, 1, 1, 3, 0, 1, 0);
            go(0, 0, 1, 1, 1, 2, 0, 1, 0);
            go(0, 0, 1, 1, 1, 1, 0, 1, 0);
            go(0, 0, 1, 1, 1, 4, 1, 1, 0);
        end
        // Gapped enable, then load beats enable.
        go(1, 2, 0, 0, 1, 2, 0, 1, 0);
        go(0, 0, 1, 0, 1, 1, 0, 1, 0);
        go(0, 0, 0, 0, 1, 1, 0, 1, 0);
        go(0, 0, 1, 0, 1, 0, 1, 0, 1);
        go(1, 7, 1, 0, 1, 7, 0, 1, 0);
        go(0, 0, 1, 0, 1, 6, 0, 1, 0);
        // Load of zero goes idle; enables ignored.
        go(1, 0, 1, 0, 1, 0, 0, 0, 0);
        go(0, 0, 1, 0, 1, 0, 0, 0, 0);
        go(0, 0, 1, 1, 1, 0, 0, 0, 0);
        // Reset mid-count.
        go(1, 7, 0, 0, 1, 7, 0, 1, 0);
        go(0, 0, 1, 0, 1, 6, 0, 1, 0);
        go(0, 0, 1, 0, 1, 5, 0, 1, 0);
        go(0, 0, 1, 0, 1, 4, 0, 1, 0);
        go(0, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
        chk("lit_gray_reset", int'(count_gray), 0);
`endif
        // Reset at the terminal edge suppresses tc.
        go(1, 1, 0, 0, 1, 1, 0, 1, 0);
        go(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Periodic with reload 1 ticks every enabled cycle; mode flip mid-count only acts at terminal.
        go(1, 1, 0, 1, 1, 1, 0, 1, 0);
        go(0, 0, 1, 1, 1, 1, 1, 1, 0);
        go(0, 0, 1, 1, 1, 1, 1, 1, 0);
        go(0, 0, 0, 0, 1, 1, 0, 1, 0);
        go(0, 0, 1, 0, 1, 0, 1, 0, 1);
        // Gray path with a multi-bit value.
        go(1, 6, 0, 0, 1, 6, 0, 1, 0);
`ifdef SYNC_DOWN_COUNTER_GRAY_OUT_EN
        chk("lit_gray_6", int'(count_gray), 5);
`endif
        go(0, 0, 1, 0, 1, 5, 0, 1, 0);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
